// File: rtl/shift_issue_stage.sv
// ---------------------------------------------------------------------------
// shift_issue_stage
//
// Feeds the 16-bit barrel shifter in the ALU datapath. It accepts MIPS-style
// shift requests (sll, srl, sllv, srlv) and decodes each one into a shifter
// operand, a 4-bit shift amount and a direction. The decoded request is
// buffered in a small FIFO so that decode timing is decoupled from execute.
// A shift amount of 16 or more is resolved here at push time: the stored
// operand is zero, so the shifter produces the same all-zero result that a
// logical shift by 16..31 would give. Requests with an illegal funct are
// consumed without being buffered and set a sticky error flag.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Valid never depends on ready. in_ready_o is
// a function of the registered occupancy only, so it has no combinational
// path from out_ready_i. Once a request is offered it must be held
// unchanged until it is accepted.
//
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   rst_i          synchronous reset, active low
//   in_valid_i     request valid
//   in_ready_o     stage can accept a request (occupancy < DEPTH)
//   funct_i        000000 sll, 000010 srl, 000100 sllv, 000110 srlv
//   shamt_field_i  immediate shift amount (sll/srl)
//   rs_data_i      variable shift amount source, bits [4:0] (sllv/srlv)
//   rt_data_i      value to be shifted
//   out_valid_o    head entry valid
//   out_ready_i    downstream consumes the head
//   sft_src_o      shifter operand (0 when empty)
//   shamt_o        shifter amount (0 when empty)
//   left_right_o   1 = left, 0 = right (0 when empty)
//   big_o          head's original amount was >= 16 (0 when empty)
//   err_o          sticky illegal-funct flag, cleared only by reset
//   count_o        current occupancy
//
// DEPTH may be 2..4. DATA_W must be 16: the shifter takes a 4-bit amount.
// ---------------------------------------------------------------------------
module shift_issue_stage #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [5:0]        funct_i,
    input  logic [4:0]        shamt_field_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] sft_src_o,
    output logic [3:0]        shamt_o,
    output logic              left_right_o,
    output logic              big_o,
    output logic              err_o,
    output logic [2:0]        count_o
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;

    // Buffered, already-decoded entries.
    logic [DATA_W-1:0] src_mem [DEPTH];
    logic [3:0]        sh_mem  [DEPTH];
    logic              lr_mem  [DEPTH];
    logic              big_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [2:0]        count_q;
    logic              err_q;

    // Decode of the offered request.
    logic              legal;
    logic [4:0]        amt;
    logic              dec_lr;
    logic              dec_big;
    logic [DATA_W-1:0] dec_src;
    logic [3:0]        dec_sh;

    logic              push;
    logic              pop;
    logic              drop;

    // Only the low five bits of rs are a shift amount; the rest is ignored.
    logic              rs_high_unused;
    assign rs_high_unused = ^rs_data_i[DATA_W-1:5];

    // The four legal functs are exactly the pattern 000xx0.
    assign legal   = (funct_i[5:3] == 3'b000) && !funct_i[0];
    assign amt     = funct_i[2] ? rs_data_i[4:0] : shamt_field_i;
    assign dec_lr  = ~funct_i[1];
    assign dec_big = amt[4];
    assign dec_src = dec_big ? '0 : rt_data_i;
    assign dec_sh  = dec_big ? 4'd0 : amt[3:0];

    assign in_ready_o  = (count_q < 3'(DEPTH));
    assign out_valid_o = (count_q != 3'd0);

    assign push = in_valid_i && in_ready_o && legal;
    assign drop = in_valid_i && in_ready_o && !legal;
    assign pop  = out_valid_o && out_ready_i;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Control state: pointers, occupancy, sticky error.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 3'd1;
            else if (pop && !push) count_q <= count_q - 3'd1;
            if (drop) err_q <= 1'b1;
        end
    end

    // Storage carries no reset: empty slots are never presented because
    // the outputs are forced to zero whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i && push) begin
            src_mem[wr_ptr_q] <= dec_src;
            sh_mem[wr_ptr_q]  <= dec_sh;
            lr_mem[wr_ptr_q]  <= dec_lr;
            big_mem[wr_ptr_q] <= dec_big;
        end
    end

    always_comb begin
        sft_src_o    = '0;
        shamt_o      = 4'd0;
        left_right_o = 1'b0;
        big_o        = 1'b0;
        if (out_valid_o) begin
            sft_src_o    = src_mem[rd_ptr_q];
            shamt_o      = sh_mem[rd_ptr_q];
            left_right_o = lr_mem[rd_ptr_q];
            big_o        = big_mem[rd_ptr_q];
        end
    end

    assign err_o   = err_q;
    assign count_o = count_q;

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Upstream feeder for the 16-bit barrel shifter in the ALU datapath.
- Accepts MIPS-style shift operations (sll, srl, sllv, srlv) over a valid/ready handshake and decodes funct into left_right and shamt.
- Resolves shift amounts of 16 or more, buffers requests in a small FIFO, and presents registered operands to the shifter.
- Decouples decode timing from the execute stage; drops illegal functs and flags them.

Parameters:
- DEPTH, 2, number of buffer entries; legal range 2..4.
- DATA_W, 16, operand width; only 16 is supported (the shifter takes a 4-bit shamt).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  stage can accept a request.
- funct_i  input  6  000000 sll, 000010 srl, 000100 sllv, 000110 srlv; any other value is illegal.
- shamt_field_i  input  5  immediate shift amount, used by sll/srl.
- rs_data_i  input  16  variable shift amount source; bits [4:0] used by sllv/srlv.
- rt_data_i  input  16  value to be shifted.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  downstream consumed the head.
- sft_src_o  output  16  operand for the shifter.
- shamt_o  output  4  shift amount for the shifter.
- left_right_o  output  1  1 = left, 0 = right.
- big_o  output  1  head's original amount was >= 16.
- err_o  output  1  sticky illegal-funct flag.
- count_o  output  3  current occupancy.

Behaviour:
- Reset (rst_i low at a clock edge): count=0, read/write pointers=0, out_valid_o=0, err_o=0. sft_src_o, shamt_o, left_right_o and big_o read 0, because a 0 output is forced whenever the buffer is empty. in_ready_o=1 from the first cycle after reset.
- Reset is applied mid-operation too: all buffered entries are discarded and no pop is signalled.
- Push condition: in_valid_i && in_ready_o && funct legal.
- Illegal funct with in_valid_i && in_ready_o: the request is consumed with no push, err_o=1 from the next cycle, and err_o stays set until reset.
- Pop condition: out_valid_o && out_ready_i.
- in_ready_o = (count < DEPTH). It is a function of registered count only and has no combinational path from out_ready_i.
- out_valid_o = (count != 0). Outputs show the head entry combinationally from storage; no bubble.
- Latency: a request pushed at edge N is visible on the outputs after edge N. Minimum accept-to-present latency is 1 cycle.
- Throughput is 1 request/cycle when out_ready_i is held high.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: no push is possible, so the full case has no simultaneous-event rule. in_valid_i is ignored; the request must be held upstream.
- Empty with out_ready_i high: no effect.
- Pointers wrap modulo DEPTH.
- Entry decode, computed at push time:
  - amt = funct[2] ? rs_data_i[4:0] : shamt_field_i.
  - left_right = ~funct[1].
  - If amt[4]=1: stored sft_src=0, shamt=0, big=1. The shifter then outputs 0, matching a logical shift by >= 16.
  - Otherwise: sft_src=rt_data_i, shamt=amt[3:0], big=0.
- Inputs are sampled only on the push edge. Later input changes do not affect stored entries.
- Entries leave in strict FIFO order.

Test Plan:
- Reset/idle: hold rst_i low 2 cycles, release -> out_valid_o=0, in_ready_o=1, err_o=0, count_o=0, sft_src_o=0.
- Immediate shift: push funct=000000, shamt_field=3, rt=16'h00F1, with out_ready_i=1 -> next cycle out_valid_o=1, sft_src_o=16'h00F1, shamt_o=3, left_right_o=1, big_o=0. Entry popped the following edge.
- Variable, big amount: push funct=000110, rs=16'h0013, rt=16'hFFFF -> sft_src_o=0, shamt_o=0, left_right_o=0, big_o=1.
- Full and backpressure: out_ready_i=0, push 3 back-to-back requests (srl by 1, 2, 3) with DEPTH=2 -> after two pushes count_o=2 and in_ready_o=0; the third request is held. Raise out_ready_i -> outputs appear in order 1,2,3 with no loss or duplication.
- Simultaneous push/pop at count=1 -> count_o stays 1 and head advances to the newer entry.
- Illegal and mid-operation reset: push funct=100000 -> no push, err_o=1 sticky across later legal traffic. Assert rst_i with count_o=2 -> next cycle count_o=0, out_valid_o=0, err_o=0.
